// File: rtl/dds_pkg.sv
// Shared constants for the AM DDS slice.
//   ADDR_W      sine_rom address width (fixed by the ROM)
//   cfg_addr_e  control-bus register map
//   CMD_*       bit positions inside a command write
//   PIPE_LAT    enabled edges from accumulator phase to aligned outputs
package dds_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    CFG_FTW_S = 2'd0,
    CFG_FTW_C = 2'd1,
    CFG_DEPTH = 2'd2,
    CFG_CMD   = 2'd3
  } cfg_addr_e;

  localparam int CMD_COMMIT = 0;
  localparam int CMD_PCLR   = 1;

  localparam int PIPE_LAT = 3;

endpackage

// File: rtl/nco_channel.sv
// One numerically controlled oscillator: shadow/active frequency tuning word,
// phase accumulator and sine look-up.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   en             advances the accumulator and the ROM read register
//   shadow_we      load shadow_wdata into the shadow FTW
//   shadow_wdata   new FTW
//   commit         copy shadow FTW to active FTW (accumulator untouched)
//   phase_clear    force the accumulator to zero, independent of en
//   raw            signed sample of the accumulator phase, one enabled edge later
module nco_channel import dds_pkg::*; #(
  parameter int PHASE_W = 15,
  parameter int DW      = 8,
  parameter int FTW_DEF = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 shadow_we,
  input  logic [PHASE_W-1:0]   shadow_wdata,
  input  logic                 commit,
  input  logic                 phase_clear,
  output logic signed [DW-1:0] raw
);

  localparam logic [PHASE_W-1:0] FTW_RST = PHASE_W'(FTW_DEF);

  logic [PHASE_W-1:0] ftw_shadow_reg;
  logic [PHASE_W-1:0] ftw_active_reg;
  logic [PHASE_W-1:0] acc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_shadow_reg <= FTW_RST;
      ftw_active_reg <= FTW_RST;
      acc_reg        <= '0;
    end else begin
      if (shadow_we) ftw_shadow_reg <= shadow_wdata;
      if (commit)    ftw_active_reg <= ftw_shadow_reg;
      // Clear wins over the add on the same edge; the add wraps silently.
      if (phase_clear) begin
        acc_reg <= '0;
      end else if (en) begin
        acc_reg <= acc_reg + ftw_active_reg;
      end
    end
  end

  sine_rom #(
    .ADDR_W (ADDR_W),
    .DW     (DW)
  ) u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .addr  (acc_reg[PHASE_W-1 -: ADDR_W]),
    .data  (raw)
  );

endmodule

// File: rtl/sine_rom.sv
// Full-wave signed sine look-up table with registered read.
// Each half-wave is a parabola 4*h*(HALF-h)/HALF^2 scaled to +/-(2^(DW-1)-1),
// so the table is exact integer arithmetic and the peak never reaches -2^(DW-1).
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous reset, active low (clears the read register)
//   en     in  read enable; the output register holds when low
//   addr   in  ADDR_W-bit phase address
//   data   out DW-bit signed sample, one cycle after addr
module sine_rom #(
  parameter int ADDR_W = 12,
  parameter int DW     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        addr,
  output logic signed [DW-1:0]     data
);

  localparam int     DEPTH = 2 ** ADDR_W;
  localparam longint HALF  = longint'(2) ** (ADDR_W - 1);
  localparam longint AMP   = longint'(2) ** (DW - 1) - 1;
  localparam int     SHIFT = 2 * ADDR_W - 4;  // divides by HALF^2/4

  function automatic logic signed [DW-1:0] sine_at(input int unsigned a);
    longint h;
    longint y;
    h = longint'(a) % HALF;
    y = (AMP * h * (HALF - h)) >> SHIFT;
    if (longint'(a) >= HALF) y = -y;
    return DW'(y);
  endfunction

  logic signed [DW-1:0] rom [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom[gi] = sine_at(gi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= rom[addr];
    end
  end

endmodule

// File: rtl/am_mod_dds.sv
// Dual-NCO AM generator: modulating tone s and carrier c, AM product
// am = c * (1 + m*s) with m = depth / 2^DEPTH_W.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   en           clock enable for accumulators and the datapath pipeline
//   cfg_we       config write strobe (independent of en)
//   cfg_addr     0 FTW_S shadow, 1 FTW_C shadow, 2 DEPTH shadow, 3 command
//   cfg_wdata    write data; command bit0 commit, bit1 phase clear
//   mod_out      modulating sine, offset binary
//   car_out      carrier sine, offset binary
//   am_out       AM product, two's complement
//   out_valid    high once the pipeline holds samples since reset/phase clear
// Pipeline: E1 ROM read, E2 envelope + carrier delay, E3 product + output align.
module am_mod_dds import dds_pkg::*; #(
  parameter int PHASE_W   = 15,
  parameter int DW        = 8,
  parameter int DEPTH_W   = 8,
  parameter int FTW_S_DEF = 64,
  parameter int FTW_C_DEF = 1920,
  parameter int DEPTH_DEF = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [PHASE_W-1:0] cfg_wdata,
  output logic [DW-1:0]      mod_out,
  output logic [DW-1:0]      car_out,
  output logic [DW-1:0]      am_out,
  output logic               out_valid
);

  // Adding 2^(DW-1) modulo 2^DW is a flip of the sign bit.
  localparam logic [DW-1:0]      OFFSET    = DW'(1) << (DW - 1);
  localparam logic [DEPTH_W-1:0] DEPTH_RST = DEPTH_W'(DEPTH_DEF);
  localparam logic [1:0]         FILL_MAX  = 2'(PIPE_LAT);

  // Config decode
  logic cmd_wr;
  logic commit;
  logic phase_clear;

  assign cmd_wr      = cfg_we && (cfg_addr == CFG_CMD);
  assign commit      = cmd_wr && cfg_wdata[CMD_COMMIT];
  assign phase_clear = cmd_wr && cfg_wdata[CMD_PCLR];

  // E1: oscillators
  logic signed [DW-1:0] raw_s;
  logic signed [DW-1:0] raw_c;

  nco_channel #(
    .PHASE_W (PHASE_W),
    .DW      (DW),
    .FTW_DEF (FTW_S_DEF)
  ) u_nco_s (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .shadow_we    (cfg_we && (cfg_addr == CFG_FTW_S)),
    .shadow_wdata (cfg_wdata),
    .commit       (commit),
    .phase_clear  (phase_clear),
    .raw          (raw_s)
  );

  nco_channel #(
    .PHASE_W (PHASE_W),
    .DW      (DW),
    .FTW_DEF (FTW_C_DEF)
  ) u_nco_c (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .shadow_we    (cfg_we && (cfg_addr == CFG_FTW_C)),
    .shadow_wdata (cfg_wdata),
    .commit       (commit),
    .phase_clear  (phase_clear),
    .raw          (raw_c)
  );

  // Depth registers
  logic [DEPTH_W-1:0] depth_shadow_reg;
  logic [DEPTH_W-1:0] depth_active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_shadow_reg <= DEPTH_RST;
      depth_active_reg <= DEPTH_RST;
    end else begin
      if (cfg_we && (cfg_addr == CFG_DEPTH)) depth_shadow_reg <= cfg_wdata[DEPTH_W-1:0];
      if (commit)                            depth_active_reg <= depth_shadow_reg;
    end
  end

  // E2: env = 2^(DW-1) + floor(depth*raw_s / 2^DEPTH_W).
  // Taking DW bits from bit DEPTH_W up is the arithmetic shift; the scaled
  // term lies in [-(2^(DW-1)-1), 2^(DW-1)-1] so the sum fits unsigned DW bits.
  logic signed [DEPTH_W+DW:0] mod_prod;
  logic [DW-1:0]              env_next;

  assign mod_prod = $signed({1'b0, depth_active_reg}) * raw_s;
  assign env_next = mod_prod[DEPTH_W +: DW] ^ OFFSET;

  // E3: am = floor(raw_c_d * env / 2^DW). |raw_c| <= 2^(DW-1)-1 and
  // env < 2^DW, so the result fits DW signed bits without saturation.
  logic signed [2*DW:0]  am_prod;
  logic signed [DW-1:0]  raw_s_d_reg;
  logic signed [DW-1:0]  raw_c_d_reg;
  logic [DW-1:0]         env_reg;

  assign am_prod = raw_c_d_reg * $signed({1'b0, env_reg});

  logic [DW-1:0] mod_out_reg;
  logic [DW-1:0] car_out_reg;
  logic [DW-1:0] am_out_reg;
  logic [1:0]    fill_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_s_d_reg <= '0;
      raw_c_d_reg <= '0;
      env_reg     <= '0;
      mod_out_reg <= '0;
      car_out_reg <= '0;
      am_out_reg  <= '0;
    end else if (en) begin
      raw_s_d_reg <= raw_s;
      raw_c_d_reg <= raw_c;
      env_reg     <= env_next;
      mod_out_reg <= raw_s_d_reg ^ OFFSET;
      car_out_reg <= raw_c_d_reg ^ OFFSET;
      am_out_reg  <= am_prod[DW +: DW];
    end
  end

  // Counts enabled edges since reset/phase clear, saturating at the latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_reg <= '0;
    end else if (phase_clear) begin
      fill_cnt_reg <= '0;
    end else if (en && (fill_cnt_reg != FILL_MAX)) begin
      fill_cnt_reg <= fill_cnt_reg + 2'd1;
    end
  end

  // Fraction bits and the redundant sign bit of the products are discarded.
  logic unused_prod_bits;
  assign unused_prod_bits = ^{mod_prod[DEPTH_W-1:0], mod_prod[DEPTH_W+DW],
                              am_prod[DW-1:0], am_prod[2*DW]};

  assign mod_out   = mod_out_reg;
  assign car_out   = car_out_reg;
  assign am_out    = am_out_reg;
  assign out_valid = (fill_cnt_reg == FILL_MAX);

endmodule

// File: tb/tb_am_mod_dds.sv
// Directed bench for am_mod_dds. Expected samples are hand-computed from the
// parabolic sine table: y = 127*h*(2048-h) >> 20, h = addr mod 2048, negated
// in the upper half. Carrier addr = 240n, modulator addr = 8n at defaults.
module tb_am_mod_dds;
  import dds_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [14:0] cfg_wdata;
  logic [7:0]  mod_out;
  logic [7:0]  car_out;
  logic [7:0]  am_out;
  logic        out_valid;

  int n_checks = 0;
  int n_errors = 0;

  am_mod_dds dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .mod_out   (mod_out),
    .car_out   (car_out),
    .am_out    (am_out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: 0x%0h", $time, tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] car, input logic [7:0] md,
                            input logic [7:0] am);
    check({tag, ".car"}, 32'(car_out), 32'(car));
    check({tag, ".mod"}, 32'(mod_out), 32'(md));
    check({tag, ".am"},  32'(am_out),  32'(am));
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [14:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a;
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) step();
    expect_out("reset", 8'h00, 8'h00, 8'h00);
    check("reset.valid", 32'(out_valid), 32'd0);
    check("reset.acc_c", 32'(dut.u_nco_c.acc_reg), 32'd0);

    // Defaults stream, with a 5-cycle en freeze after edge 4.
    rst_n = 1'b1;
    en    = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      step();
      check($sformatf("e%0d.valid", k), 32'(out_valid), 32'(k >= 3));
      check($sformatf("e%0d.acc_c", k), 32'(dut.u_nco_c.acc_reg), (1920 * k) % 32768);
      case (k)
        3:  expect_out("s0", 8'h80, 8'h80, 8'h00);
        4:  expect_out("s1", 8'hB4, 8'h81, 8'h1A);
        5:  expect_out("s2", 8'hDB, 8'h83, 8'h2D);
        6:  expect_out("s3", 8'hF3, 8'h85, 8'h3A);
        12: expect_out("s9", 8'h66, 8'h91, 8'hF2);
        default: ;
      endcase
      if (k == 4) begin
        en = 1'b0;
        for (int f = 0; f < 5; f++) begin
          step();
          expect_out("freeze", 8'hB4, 8'h81, 8'h1A);
          check("freeze.acc_c", 32'(dut.u_nco_c.acc_reg), 32'd7680);
          check("freeze.valid", 32'(out_valid), 32'd1);
        end
        en = 1'b1;
      end
    end
    check("wrap.acc_c", 32'(dut.u_nco_c.acc_reg), 32'd1792);

    // Shadow FTW write without commit leaves the increment alone.
    a = 1792;
    cfg_write(CFG_FTW_C, 15'd4096);
    a = (a + 1920) % 32768;
    check("shadow.acc_c", 32'(dut.u_nco_c.acc_reg), a);
    for (int i = 0; i < 10; i++) begin
      step();
      a = (a + 1920) % 32768;
      check("hold.acc_c", 32'(dut.u_nco_c.acc_reg), a);
    end
    cfg_write(CFG_CMD, 15'd1);
    a = (a + 1920) % 32768;
    check("commit.acc_c", 32'(dut.u_nco_c.acc_reg), a);
    for (int i = 0; i < 3; i++) begin
      step();
      a = (a + 4096) % 32768;
      check("newftw.acc_c", 32'(dut.u_nco_c.acc_reg), a);
    end

    // Depth 0, carrier back to 1920, committed together with a phase clear.
    cfg_write(CFG_DEPTH, 15'd0);
    cfg_write(CFG_FTW_C, 15'd1920);
    cfg_write(CFG_CMD, 15'd3);
    check("pclr.acc_c", 32'(dut.u_nco_c.acc_reg), 32'd0);
    check("pclr.acc_s", 32'(dut.u_nco_s.acc_reg), 32'd0);
    check("pclr.valid", 32'(out_valid), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      step();
      check($sformatf("d0.e%0d.valid", j), 32'(out_valid), 32'(j >= 3));
      case (j)
        3:  expect_out("d0.s0", 8'h80, 8'h80, 8'h00);
        4:  expect_out("d0.s1", 8'hB4, 8'h81, 8'h1A);
        6:  expect_out("d0.s3", 8'hF3, 8'h85, 8'h39);
        12: expect_out("d0.s9", 8'h66, 8'h91, 8'hF3);
        default: ;
      endcase
    end

    // Depth 255 with the modulator at its negative peak: env = 1.
    cfg_write(CFG_FTW_S, 15'd24576);
    cfg_write(CFG_DEPTH, 15'd255);
    cfg_write(CFG_CMD, 15'd3);
    check("pclr2.valid", 32'(out_valid), 32'd0);
    for (int j = 1; j <= 5; j++) begin
      step();
      case (j)
        3: expect_out("d255.s0", 8'h80, 8'h80, 8'h00);
        4: expect_out("d255.s1", 8'hB4, 8'h01, 8'h00);
        5: expect_out("d255.s2", 8'hDB, 8'h80, 8'h2D);
        default: ;
      endcase
    end

    // Asynchronous reset mid-cycle.
    #3;
    rst_n = 1'b0;
    #1;
    expect_out("areset", 8'h00, 8'h00, 8'h00);
    check("areset.valid", 32'(out_valid), 32'd0);
    check("areset.ftw_s", 32'(dut.u_nco_s.ftw_active_reg), 32'd64);
    check("areset.ftw_c", 32'(dut.u_nco_c.ftw_active_reg), 32'd1920);
    check("areset.acc_c", 32'(dut.u_nco_c.acc_reg), 32'd0);
    rst_n = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      check($sformatf("post.e%0d.valid", j), 32'(out_valid), 32'(j >= 3));
      case (j)
        3: expect_out("post.s0", 8'h80, 8'h80, 8'h00);
        4: expect_out("post.s1", 8'hB4, 8'h81, 8'h1A);
        default: ;
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
